alu_arb: RTL and testbench

- Shares one ALU functional unit between NREQ requesters, for example the EXE stage and the CSR/address-generation path.
- Arbitration is round-robin. The block drives the shared ALU combinationally from the granted requester and registers the result into a one-entry response buffer.
- Each requester sees a valid/ready request channel and a valid/ready response channel.
- The block sits inside EXE, between the requesters and the single alu_fu instance (AFU interface).

---
 rtl/alu_arb_pkg.sv | 36 +++
 rtl/afu_if.sv | 28 ++
 rtl/alu_arb_rr_grant.sv | 32 +++
 rtl/alu_arb.sv | 103 ++++++++++
 tb/tb_alu_arb.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arb_pkg.sv
// Shared ALU request/select types and the arbiter state encoding.
package alu_arb_pkg;

  localparam int ALU_NREQ = 2;

  typedef enum logic [1:0] {
    AM_RS1,
    AM_RS2,
    AM_IMM,
    AM_PC
  } ALU_SEL_TYPE;

  typedef enum logic [3:0] {
    A_ADD,
    A_SUB,
    A_SLT,
    A_SLTU,
    A_AND,
    A_OR,
    A_XOR,
    A_SLL,
    A_SRL,
    A_SRA
  } ALU_OP_TYPE;

  typedef enum logic {
    ARB_IDLE,
    ARB_RESP
  } ARB_STATE_TYPE;

  // Round-robin successor: the requester after g, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
    return (g == n - 1) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/afu_if.sv
// Operand/result bundle between a requester-side master and the shared alu_fu.
interface afu_if
  import alu_arb_pkg::*;
#(
  parameter int RSZ   = 32,
  parameter int PC_SZ = 32
);

  logic [RSZ-1:0]   rs1_data;
  logic [RSZ-1:0]   rs2_data;
  logic [RSZ-1:0]   imm;
  logic [PC_SZ-1:0] pc;
  ALU_SEL_TYPE      sel_x;
  ALU_SEL_TYPE      sel_y;
  ALU_OP_TYPE       op;
  logic [RSZ-1:0]   rd_data;

  modport master (
    output rs1_data, rs2_data, imm, pc, sel_x, sel_y, op,
    input  rd_data
  );

  modport slave (
    input  rs1_data, rs2_data, imm, pc, sel_x, sel_y, op,
    output rd_data
  );

endinterface

// File: rtl/alu_arb_rr_grant.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_grant #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [IW-1:0] cand;

  // idx falls back to ptr so a consumer can use it as a mux select unconditionally.
  always_comb begin
    grant = '0;
    idx   = ptr;
    found = 1'b0;
    cand  = ptr;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (en && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/alu_arb.sv
// Round-robin sharing of one ALU between NREQ requesters with a one-entry
// registered response buffer.
module alu_arb
  import alu_arb_pkg::*;
#(
  parameter int NREQ  = ALU_NREQ,
  parameter int RSZ   = 32,
  parameter int PC_SZ = 32
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              flush_in,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [RSZ-1:0]    req_rs1_data [NREQ],
  input  logic [RSZ-1:0]    req_rs2_data [NREQ],
  input  logic [RSZ-1:0]    req_imm      [NREQ],
  input  logic [PC_SZ-1:0]  req_pc       [NREQ],
  input  ALU_SEL_TYPE       req_sel_x    [NREQ],
  input  ALU_SEL_TYPE       req_sel_y    [NREQ],
  input  ALU_OP_TYPE        req_op       [NREQ],
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [RSZ-1:0]    rsp_data,
  afu_if.master             afu_bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  ARB_STATE_TYPE   state;
  ARB_STATE_TYPE   next_state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   grant_idx;
  logic [NREQ-1:0] grant;
  logic            grant_found;
  logic            accept_win;
  logic            grant_en;

  // Window reopens in RESP when the owner drains, giving one result per cycle.
  assign accept_win = (state == ARB_IDLE) || rsp_ready[owner];
  assign grant_en   = reset_in && !flush_in && accept_win;

  rr_grant #(
    .N  (NREQ),
    .IW (IW)
  ) u_rr_grant (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .en    (grant_en),
    .grant (grant),
    .idx   (grant_idx),
    .found (grant_found)
  );

  assign req_ready = grant;

  // With no grant, grant_idx equals rr_ptr and the ALU result is simply unused.
  assign afu_bus.rs1_data = req_rs1_data[grant_idx];
  assign afu_bus.rs2_data = req_rs2_data[grant_idx];
  assign afu_bus.imm      = req_imm[grant_idx];
  assign afu_bus.pc       = req_pc[grant_idx];
  assign afu_bus.sel_x    = req_sel_x[grant_idx];
  assign afu_bus.sel_y    = req_sel_y[grant_idx];
  assign afu_bus.op       = req_op[grant_idx];

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state <= ARB_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    rsp_valid  = '0;
    if (state == ARB_RESP) begin
      rsp_valid[owner] = 1'b1;
    end
    if (flush_in) begin
      next_state = ARB_IDLE;
    end else if (grant_found) begin
      next_state = ARB_RESP;
    end else if ((state == ARB_RESP) && rsp_ready[owner]) begin
      next_state = ARB_IDLE;
    end
  end

  // Response buffer stage: capture the ALU result of the accepted request.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      rr_ptr   <= '0;
      owner    <= '0;
      rsp_data <= '0;
    end else if (grant_found) begin
      rsp_data <= afu_bus.rd_data;
      owner    <= grant_idx;
      rr_ptr   <= IW'(rr_next(32'(grant_idx), NREQ));
    end
  end

endmodule

// File: tb/tb_alu_arb.sv
// Bench for alu_arb: directed scenarios plus random traffic against a transaction model.
module tb_alu_arb;
  import alu_arb_pkg::*;

  localparam int N   = 2;
  localparam int N3  = 3;
  localparam int RSZ = 32;
  localparam int PSZ = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int asserts = 0;
  int fails   = 0;

  // two-requester instance
  logic              rst_n;
  logic              flush;
  logic [N-1:0]      rv;
  logic [N-1:0]      rdy;
  logic [N-1:0]      vld;
  logic [N-1:0]      rsr;
  logic [RSZ-1:0]    rs1 [N];
  logic [RSZ-1:0]    rs2 [N];
  logic [RSZ-1:0]    imm [N];
  logic [PSZ-1:0]    pc  [N];
  ALU_SEL_TYPE       sx  [N];
  ALU_SEL_TYPE       sy  [N];
  ALU_OP_TYPE        op  [N];
  logic [RSZ-1:0]    data;

  // three-requester instance
  logic              rst3_n;
  logic              flush3;
  logic [N3-1:0]     rv3;
  logic [N3-1:0]     rdy3;
  logic [N3-1:0]     vld3;
  logic [N3-1:0]     rsr3;
  logic [RSZ-1:0]    rs1_3 [N3];
  logic [RSZ-1:0]    rs2_3 [N3];
  logic [RSZ-1:0]    imm_3 [N3];
  logic [PSZ-1:0]    pc_3  [N3];
  ALU_SEL_TYPE       sx_3  [N3];
  ALU_SEL_TYPE       sy_3  [N3];
  ALU_OP_TYPE        op_3  [N3];
  logic [RSZ-1:0]    data3;

  afu_if #(.RSZ(RSZ), .PC_SZ(PSZ)) afu2 ();
  afu_if #(.RSZ(RSZ), .PC_SZ(PSZ)) afu3 ();

  alu_arb #(.NREQ(N), .RSZ(RSZ), .PC_SZ(PSZ)) dut (
    .clk_in       (clk),
    .reset_in     (rst_n),
    .flush_in     (flush),
    .req_valid    (rv),
    .req_ready    (rdy),
    .req_rs1_data (rs1),
    .req_rs2_data (rs2),
    .req_imm      (imm),
    .req_pc       (pc),
    .req_sel_x    (sx),
    .req_sel_y    (sy),
    .req_op       (op),
    .rsp_valid    (vld),
    .rsp_ready    (rsr),
    .rsp_data     (data),
    .afu_bus      (afu2)
  );

  alu_arb #(.NREQ(N3), .RSZ(RSZ), .PC_SZ(PSZ)) dut3 (
    .clk_in       (clk),
    .reset_in     (rst3_n),
    .flush_in     (flush3),
    .req_valid    (rv3),
    .req_ready    (rdy3),
    .req_rs1_data (rs1_3),
    .req_rs2_data (rs2_3),
    .req_imm      (imm_3),
    .req_pc       (pc_3),
    .req_sel_x    (sx_3),
    .req_sel_y    (sy_3),
    .req_op       (op_3),
    .rsp_valid    (vld3),
    .rsp_ready    (rsr3),
    .rsp_data     (data3),
    .afu_bus      (afu3)
  );

  function automatic logic [31:0] opnd(input ALU_SEL_TYPE s, input logic [31:0] a, b, i, p);
    case (s)
      AM_RS1:  return a;
      AM_RS2:  return b;
      AM_IMM:  return i;
      default: return p;
    endcase
  endfunction

  function automatic logic [31:0] alu_ref(input ALU_OP_TYPE o, input logic [31:0] x, y);
    case (o)
      A_ADD:   return x + y;
      A_SUB:   return x - y;
      A_SLT:   return {31'b0, $signed(x) < $signed(y)};
      A_SLTU:  return {31'b0, x < y};
      A_AND:   return x & y;
      A_OR:    return x | y;
      A_XOR:   return x ^ y;
      A_SLL:   return x << y[4:0];
      A_SRL:   return x >> y[4:0];
      A_SRA:   return $signed(x) >>> y[4:0];
      default: return '0;
    endcase
  endfunction

  // stand-in for the parent-level alu_fu
  assign afu2.rd_data = alu_ref(afu2.op,
                                opnd(afu2.sel_x, afu2.rs1_data, afu2.rs2_data, afu2.imm, afu2.pc),
                                opnd(afu2.sel_y, afu2.rs1_data, afu2.rs2_data, afu2.imm, afu2.pc));
  assign afu3.rd_data = alu_ref(afu3.op,
                                opnd(afu3.sel_x, afu3.rs1_data, afu3.rs2_data, afu3.imm, afu3.pc),
                                opnd(afu3.sel_y, afu3.rs1_data, afu3.rs2_data, afu3.imm, afu3.pc));

  function automatic logic [31:0] req_result(input int i);
    return alu_ref(op[i], opnd(sx[i], rs1[i], rs2[i], imm[i], pc[i]),
                          opnd(sy[i], rs1[i], rs2[i], imm[i], pc[i]));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set2(input int i, input ALU_OP_TYPE o, input ALU_SEL_TYPE x, y,
                      input logic [31:0] a, b, im, p);
    op[i] = o; sx[i] = x; sy[i] = y; rs1[i] = a; rs2[i] = b; imm[i] = im; pc[i] = p;
  endtask

  task automatic set3(input int i, input ALU_OP_TYPE o, input ALU_SEL_TYPE x, y,
                      input logic [31:0] a, b, im, p);
    op_3[i] = o; sx_3[i] = x; sy_3[i] = y; rs1_3[i] = a; rs2_3[i] = b; imm_3[i] = im; pc_3[i] = p;
  endtask

  task automatic rand_fields(input int i);
    op[i]  = ALU_OP_TYPE'(4'($urandom_range(0, 9)));
    sx[i]  = ALU_SEL_TYPE'(2'($urandom_range(0, 3)));
    sy[i]  = ALU_SEL_TYPE'(2'($urandom_range(0, 3)));
    rs1[i] = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 40);
    rs2[i] = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 40);
    imm[i] = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 40);
    pc[i]  = $urandom;
  endtask

  // Transaction model: a buffer that is either empty or holds one result for an owner.
  logic          m_busy   = 1'b0;
  int            m_owner  = 0;
  int            m_ptr    = 0;
  logic [31:0]   m_data   = '0;
  logic [N-1:0]  exp_acc  = '0;
  logic [N-1:0]  prev_rv  = '0;
  logic [N-1:0]  prev_acc = '0;
  logic          prev_rst = 1'b0;
  logic          chk_en   = 1'b1;

  always @(negedge clk) begin : compare
    int g;
    int s;
    logic [N-1:0] e_ready;
    logic [N-1:0] e_valid;
    if (!rst_n) begin
      m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_data = '0;
    end
    g = -1;
    if (rst_n && !flush && (!m_busy || rsr[m_owner])) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && rv[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    e_ready = '0;
    if (g >= 0) e_ready[g] = 1'b1;
    e_valid = '0;
    if (m_busy) e_valid[m_owner] = 1'b1;
    s = (g >= 0) ? g : m_ptr;
    if (chk_en) begin
      chk("req_ready", 32'(rdy), 32'(e_ready));
      chk("rsp_valid", 32'(vld), 32'(e_valid));
      chk("rsp_data", data, m_data);
      chk("afu_op", 32'(afu2.op), 32'(op[s]));
      chk("afu_rs1", afu2.rs1_data, rs1[s]);
      if (prev_rst && rst_n) begin
        for (int i = 0; i < N; i++) begin
          if (prev_rv[i] && !prev_acc[i]) chk("hold_valid", 32'(rv[i]), 32'd1);
        end
      end
    end
    prev_rv  = rv;
    prev_acc = e_ready;
    prev_rst = rst_n;
    exp_acc  = e_ready;
    if (rst_n) begin
      if (g >= 0) begin
        m_data = req_result(g); m_owner = g; m_ptr = (g + 1) % N; m_busy = 1'b1;
      end else if (flush || (m_busy && rsr[m_owner])) begin
        m_busy = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within 500000 time units");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; rst3_n = 1'b1; flush = 1'b0; flush3 = 1'b0;
    rv = '0; rsr = '0; rv3 = '0; rsr3 = '0;
    for (int i = 0; i < N; i++) set2(i, A_ADD, AM_RS1, AM_RS2, 0, 0, 0, 0);
    for (int i = 0; i < N3; i++) set3(i, A_ADD, AM_RS1, AM_RS2, 0, 0, 0, 0);
    #1;
    rst_n = 1'b0; rst3_n = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_ready", 32'(rdy), 32'h0);
    chk("rst_valid", 32'(vld), 32'h0);
    chk("rst_data", data, 32'h0);

    // single request after reset release: 5 + 7
    tick(); rst_n = 1'b1;
    tick();
    set2(0, A_ADD, AM_RS1, AM_IMM, 5, 0, 7, 0);
    set2(1, A_OR, AM_RS1, AM_IMM, 32'hAAAA_0001, 0, 32'h30, 0);
    rv = 2'b01;
    @(negedge clk); chk("t1_ready", 32'(rdy), 32'h1);
    tick(); rv = 2'b00;
    @(negedge clk);
    chk("t1_valid", 32'(vld), 32'h1);
    chk("t1_data", data, 32'd12);
    chk("t1_ptr_is_1", afu2.rs1_data, 32'hAAAA_0001);

    // owner 0 drains while requester 1 is accepted in the same cycle
    tick(); rsr = 2'b01; rv = 2'b10;
    @(negedge clk); chk("b2b_ready", 32'(rdy), 32'h2);
    tick(); rv = 2'b00; rsr = 2'b10;
    set2(0, A_SUB, AM_RS1, AM_RS2, 3, 5, 0, 0);
    set2(1, A_SLT, AM_RS1, AM_RS2, 32'hFFFF_FFFF, 1, 0, 0);
    @(negedge clk);
    chk("b2b_valid", 32'(vld), 32'h2);
    chk("b2b_data", data, 32'hAAAA_0031);

    // contention from pointer 0: grants alternate
    tick(); rv = 2'b11; rsr = 2'b11;
    @(negedge clk); chk("c_ready0", 32'(rdy), 32'h1);
    tick(); set2(0, A_AND, AM_RS1, AM_RS2, 32'hF0F0, 32'hFF00, 0, 0);
    @(negedge clk);
    chk("c_ready1", 32'(rdy), 32'h2);
    chk("c_valid1", 32'(vld), 32'h1);
    chk("c_sub", data, 32'hFFFF_FFFE);
    tick(); set2(1, A_ADD, AM_PC, AM_IMM, 0, 0, 4, 32'h100);
    @(negedge clk);
    chk("c_ready2", 32'(rdy), 32'h1);
    chk("c_valid2", 32'(vld), 32'h2);
    chk("c_slt", data, 32'h1);
    tick(); rv = 2'b10;
    @(negedge clk);
    chk("c_ready3", 32'(rdy), 32'h2);
    chk("c_and", data, 32'hF000);
    tick(); rv = 2'b00;
    @(negedge clk);
    chk("c_valid4", 32'(vld), 32'h2);
    chk("c_pc_add", data, 32'h104);

    // backpressure by owner 0 while requester 1 waits
    tick(); set2(0, A_ADD, AM_RS1, AM_RS2, 1, 1, 0, 0); rv = 2'b01; rsr = 2'b00;
    @(negedge clk); chk("bp_first", 32'(rdy), 32'h1);
    tick(); set2(1, A_SUB, AM_RS1, AM_RS2, 10, 3, 0, 0); rv = 2'b10;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      chk("bp_ready", 32'(rdy), 32'h0);
      chk("bp_valid", 32'(vld), 32'h1);
      chk("bp_data", data, 32'h2);
      tick();
    end
    rsr = 2'b01;
    @(negedge clk); chk("bp_release", 32'(rdy), 32'h2);
    tick(); set2(0, A_XOR, AM_RS1, AM_RS2, 32'hFF, 32'h0F, 0, 0); rv = 2'b01; rsr = 2'b10;
    @(negedge clk);
    chk("bp_data1", data, 32'h7);
    chk("pre_flush_ready", 32'(rdy), 32'h1);

    // flush while owner 0 is ready and requester 1 waits
    tick(); set2(1, A_SRA, AM_RS1, AM_IMM, 32'h8000_0000, 0, 4, 0);
    rv = 2'b10; rsr = 2'b01; flush = 1'b1;
    @(negedge clk);
    chk("fl_ready", 32'(rdy), 32'h0);
    chk("fl_data", data, 32'hF0);
    tick(); flush = 1'b0; set2(0, A_ADD, AM_RS1, AM_RS2, 32'h10, 32'h20, 0, 0);
    rv = 2'b11; rsr = 2'b00;
    @(negedge clk);
    chk("fl_valid_drop", 32'(vld), 32'h0);
    chk("fl_ptr_kept", 32'(rdy), 32'h2);
    tick(); rv = 2'b01;
    @(negedge clk); chk("fl_sra", data, 32'hF800_0000);

    // asynchronous reset between edges while a result is buffered
    tick(); rst_n = 1'b0; #1;
    chk("ar_valid", 32'(vld), 32'h0);
    chk("ar_ready", 32'(rdy), 32'h0);
    rv = 2'b00;
    @(negedge clk); chk("ar_data", data, 32'h0);
    tick(); rst_n = 1'b1; rv = 2'b11;
    @(negedge clk); chk("ar_ptr0", 32'(rdy), 32'h1);
    tick(); rv = 2'b10; rsr = 2'b11;
    @(negedge clk);
    chk("ar_ready1", 32'(rdy), 32'h2);
    chk("ar_data1", data, 32'h30);
    tick(); rv = 2'b00;

    // three requesters: lone request from 2, then all three from pointer 0
    tick(); rst3_n = 1'b1;
    for (int i = 0; i < N3; i++) set3(i, A_ADD, AM_RS1, AM_RS2, 32'(i * 16), 1, 0, 0);
    set3(2, A_ADD, AM_RS1, AM_RS2, 2, 2, 0, 0);
    rv3 = 3'b100; rsr3 = 3'b111;
    @(negedge clk); chk("n3_ready2", 32'(rdy3), 32'h4);
    tick(); set3(2, A_ADD, AM_RS1, AM_RS2, 32'h20, 1, 0, 0); rv3 = 3'b111;
    @(negedge clk);
    chk("n3_wrap", 32'(rdy3), 32'h1);
    chk("n3_valid2", 32'(vld3), 32'h4);
    chk("n3_data2", data3, 32'h4);
    tick(); rv3 = 3'b110;
    @(negedge clk);
    chk("n3_ready1", 32'(rdy3), 32'h2);
    chk("n3_data0", data3, 32'h1);
    tick(); rv3 = 3'b100;
    @(negedge clk);
    chk("n3_ready_last", 32'(rdy3), 32'h4);
    chk("n3_data1", data3, 32'h11);
    tick(); rv3 = 3'b000;
    @(negedge clk);
    chk("n3_valid_last", 32'(vld3), 32'h4);
    chk("n3_data_last", data3, 32'h21);

    // random traffic with flushes, backpressure and occasional resets
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
      flush = ($urandom_range(0, 19) == 0);
      rsr = N'($urandom);
      for (int i = 0; i < N; i++) begin
        if (!(rst_n && rv[i] && !exp_acc[i])) begin
          rv[i] = ($urandom_range(0, 9) < 6);
          rand_fields(i);
        end
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
